// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory stage of the integer pipeline. ALU results pass straight through
// with a latency of one cycle. Aligned loads and stores are issued on the
// data bus; the stage stalls upstream until the bus completes. Misaligned
// memory ops are reported as a fault, with no bus request, one cycle later.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid        execute-stage entry valid
//   in_load/store   memory op class (both 0 = ALU pass-through)
//   in_addr         effective address
//   in_wdata        store data, right-aligned
//   in_size         0=byte 1=half 2=word 3=dword
//   in_sign         sign-extend load data
//   in_rd/wen/alu   destination, write enable, ALU result
//   dreq_*          data-bus request (valid, addr, lane-aligned data, strobe, size)
//   dresp_ok/data   data-bus completion and dword-aligned read data
//   stall           upstream must hold all in_* while high
//   out_*           registered result toward the MEM/WR register
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_sign,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic [63:0] in_alu,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [63:0] dreq_data,
  output logic [7:0]  dreq_strobe,
  output logic [1:0]  dreq_size,
  input  logic        dresp_ok,
  input  logic [63:0] dresp_data,
  output logic        stall,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [63:0] out_result,
  output logic        out_misalign
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request registers: held unchanged for the whole WAIT period.
  logic [63:0] r_dreq_addr;
  logic [63:0] r_dreq_data;
  logic [7:0]  r_dreq_strobe;
  logic [1:0]  r_dreq_size;

  // Writeback attributes of the outstanding op.
  logic [4:0]  r_rd;
  logic        r_wen;
  logic        r_sign;
  logic        r_is_store;

  // Output registers.
  logic        r_out_valid;
  logic [4:0]  r_out_rd;
  logic        r_out_wen;
  logic [63:0] r_out_result;
  logic        r_out_misalign;

  // Per-cycle decisions from the control process.
  logic        w_pass;
  logic        w_fault;
  logic        w_issue;
  logic        w_complete;
  logic        w_stall;

  logic        w_is_mem;
  logic        w_misalign;
  logic [3:0]  w_nbytes;
  logic [3:0]  w_lane_end;
  logic [7:0]  w_strobe;
  logic [63:0] w_store_data;
  logic [63:0] w_load_shifted;
  logic [63:0] w_load_data;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  assign w_is_mem = in_load | in_store;

  // Natural alignment: the low log2(size) address bits must be zero.
  always_comb begin
    case (in_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = in_addr[0];
      2'd2:    w_misalign = |in_addr[1:0];
      default: w_misalign = |in_addr[2:0];
    endcase
  end

  assign w_nbytes     = 4'd1 << in_size;
  assign w_lane_end   = {1'b0, in_addr[2:0]} + w_nbytes;
  assign w_store_data = in_wdata << {in_addr[2:0], 3'b000};

  // Byte lane gi is written when it lies in [offset, offset + nbytes).
  // Loads drive an all-zero strobe.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
      localparam logic [3:0] LANE = 4'(gi);
      assign w_strobe[gi] = in_store
                          && (LANE >= {1'b0, in_addr[2:0]})
                          && (LANE < w_lane_end);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Load data extraction: shift the addressed bytes down to bit 0, then
  // zero- or sign-extend from the access width.
  // -------------------------------------------------------------------------
  assign w_load_shifted = dresp_data >> {r_dreq_addr[2:0], 3'b000};

  always_comb begin
    case (r_dreq_size)
      2'd0:    w_load_data = {{56{r_sign & w_load_shifted[7]}},  w_load_shifted[7:0]};
      2'd1:    w_load_data = {{48{r_sign & w_load_shifted[15]}}, w_load_shifted[15:0]};
      2'd2:    w_load_data = {{32{r_sign & w_load_shifted[31]}}, w_load_shifted[31:0]};
      default: w_load_data = w_load_shifted;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_pass       = 1'b0;
    w_fault      = 1'b0;
    w_issue      = 1'b0;
    w_complete   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // dresp_ok is deliberately not looked at here: a stray
        // completion with nothing outstanding has no effect.
        if (in_valid) begin
          if (!w_is_mem) begin
            w_pass = 1'b1;
          end else if (w_misalign) begin
            w_fault = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_stall      = 1'b1;
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dresp_ok) begin
          // Releasing stall here lets the next op arrive in the very next
          // IDLE cycle, so back-to-back ops lose no extra cycle.
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Reset wins over everything, including a completion in the same cycle.
    if (rst) begin
      w_state_next = ST_IDLE;
      w_stall      = 1'b0;
      w_pass       = 1'b0;
      w_fault      = 1'b0;
      w_issue      = 1'b0;
      w_complete   = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Request latch
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dreq_addr   <= '0;
      r_dreq_data   <= '0;
      r_dreq_strobe <= '0;
      r_dreq_size   <= '0;
      r_rd          <= '0;
      r_wen         <= 1'b0;
      r_sign        <= 1'b0;
      r_is_store    <= 1'b0;
    end else if (w_issue) begin
      r_dreq_addr   <= in_addr;
      r_dreq_data   <= w_store_data;
      r_dreq_strobe <= w_strobe;
      r_dreq_size   <= in_size;
      r_rd          <= in_rd;
      r_wen         <= in_wen;
      r_sign        <= in_sign;
      r_is_store    <= in_store;
    end
  end

  // -------------------------------------------------------------------------
  // Result register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_rd       <= '0;
      r_out_wen      <= 1'b0;
      r_out_result   <= '0;
      r_out_misalign <= 1'b0;
    end else begin
      r_out_valid <= w_pass | w_fault | w_complete;
      if (w_pass) begin
        r_out_rd       <= in_rd;
        r_out_wen      <= in_wen;
        r_out_result   <= in_alu;
        r_out_misalign <= 1'b0;
      end else if (w_fault) begin
        r_out_rd       <= in_rd;
        r_out_wen      <= 1'b0;
        r_out_result   <= '0;
        r_out_misalign <= 1'b1;
      end else if (w_complete) begin
        r_out_rd       <= r_rd;
        r_out_wen      <= r_is_store ? 1'b0 : r_wen;
        r_out_result   <= r_is_store ? 64'd0 : w_load_data;
        r_out_misalign <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dreq_valid   = (r_state == ST_WAIT);
  assign dreq_addr    = r_dreq_addr;
  assign dreq_data    = r_dreq_data;
  assign dreq_strobe  = r_dreq_strobe;
  assign dreq_size    = r_dreq_size;
  assign stall        = w_stall;
  assign out_valid    = r_out_valid;
  assign out_rd       = r_out_rd;
  assign out_wen      = r_out_wen;
  assign out_result   = r_out_result;
  assign out_misalign = r_out_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Directed and random transactions against mem_stage. Expected values come
// from arithmetic on the operation (mask/shift/extend), not from the DUT.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_load;
  logic        in_store;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [1:0]  in_size;
  logic        in_sign;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [63:0] in_alu;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [63:0] dreq_data;
  logic [7:0]  dreq_strobe;
  logic [1:0]  dreq_size;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        stall;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_result;
  logic        out_misalign;

  int compared   = 0;
  int mismatched = 0;
  int txn        = 0;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_size      (in_size),
    .in_sign      (in_sign),
    .in_rd        (in_rd),
    .in_wen       (in_wen),
    .in_alu       (in_alu),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_data    (dreq_data),
    .dreq_strobe  (dreq_strobe),
    .dreq_size    (dreq_size),
    .dresp_ok     (dresp_ok),
    .dresp_data   (dresp_data),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_rd       (out_rd),
    .out_wen      (out_wen),
    .out_result   (out_result),
    .out_misalign (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic logic [63:0] model_load(input logic [63:0] resp, input int off,
                                             input int size, input bit sgn);
    int          nb;
    logic [63:0] mask;
    logic [63:0] v;
    nb   = 1 << size;
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
    v    = (resp >> (off * 8)) & mask;
    if (sgn && v[nb * 8 - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input int off, input int size);
    int s;
    s = ((1 << (1 << size)) - 1) << off;
    return 8'(s & 255);
  endfunction

  // ---- transactions --------------------------------------------------------
  task automatic do_idle();
    in_valid = 1'b0;
    dresp_ok = 1'($urandom_range(0, 1));
    #1;
    chk("idle_stall", stall, 0);
    tick();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_dreq_valid", dreq_valid, 0);
    dresp_ok = 1'b0;
    txn++;
    $display("txn %0d idle", txn);
  endtask

  task automatic do_alu(input logic [4:0] rd, input bit wen, input logic [63:0] alu);
    in_valid = 1'b1; in_load = 1'b0; in_store = 1'b0;
    in_rd = rd; in_wen = wen; in_alu = alu;
    in_addr = {$urandom, $urandom}; in_size = 2'($urandom_range(0, 3));
    // A stray completion while idle must not matter.
    dresp_ok = 1'($urandom_range(0, 1));
    dresp_data = {$urandom, $urandom};
    #1;
    chk("alu_stall", stall, 0);
    tick();
    chk("alu_out_valid", out_valid, 1);
    chk("alu_out_rd", out_rd, rd);
    chk("alu_out_wen", out_wen, wen);
    chk("alu_out_result", out_result, alu);
    chk("alu_out_misalign", out_misalign, 0);
    chk("alu_dreq_valid", dreq_valid, 0);
    dresp_ok = 1'b0;
    txn++;
    $display("txn %0d alu rd=%0d wen=%0d alu=0x%0h", txn, rd, wen, alu);
  endtask

  task automatic do_mem(input bit is_store, input logic [63:0] addr, input logic [63:0] wdata,
                        input int size, input bit sgn, input logic [4:0] rd, input bit wen,
                        input int waits, input logic [63:0] resp);
    int          off;
    bit          mis;
    int          stall_cycles;
    logic [63:0] exp_data;
    logic [7:0]  exp_strobe;
    logic [63:0] exp_res;
    off  = int'(addr[2:0]);
    mis  = (addr % (64'd1 << size)) != 0;
    exp_data   = wdata << (off * 8);
    exp_strobe = is_store ? model_strobe(off, size) : 8'h00;
    exp_res    = is_store ? 64'd0 : model_load(resp, off, size, sgn);
    in_valid = 1'b1; in_load = !is_store; in_store = is_store;
    in_addr = addr; in_wdata = wdata; in_size = 2'(size); in_sign = sgn;
    in_rd = rd; in_wen = wen; in_alu = {$urandom, $urandom};
    dresp_ok = 1'b0;
    #1;
    if (mis) begin
      chk("mis_stall", stall, 0);
      tick();
      chk("mis_dreq_valid", dreq_valid, 0);
      chk("mis_out_valid", out_valid, 1);
      chk("mis_out_misalign", out_misalign, 1);
      chk("mis_out_wen", out_wen, 0);
      chk("mis_out_result", out_result, 0);
      txn++;
      $display("txn %0d misaligned %s addr=0x%0h size=%0d", txn, is_store ? "store" : "load", addr, size);
      return;
    end
    stall_cycles = 0;
    if (stall) stall_cycles++;
    chk("issue_stall", stall, 1);
    tick();
    chk("issue_out_valid", out_valid, 0);
    for (int w = 0; w <= waits; w++) begin
      dresp_ok = (w == waits);
      dresp_data = (w == waits) ? resp : {$urandom, $urandom};
      #1;
      if (stall) stall_cycles++;
      chk("wait_dreq_valid", dreq_valid, 1);
      chk("wait_dreq_addr", dreq_addr, addr);
      chk("wait_dreq_size", dreq_size, 64'(size));
      chk("wait_dreq_strobe", dreq_strobe, exp_strobe);
      if (is_store) chk("wait_dreq_data", dreq_data, exp_data);
      chk("wait_stall", stall, (w == waits) ? 0 : 1);
      tick();
      if (w != waits) chk("wait_out_valid", out_valid, 0);
    end
    dresp_ok = 1'b0;
    chk("done_out_valid", out_valid, 1);
    chk("done_out_rd", out_rd, rd);
    chk("done_out_wen", out_wen, is_store ? 0 : wen);
    chk("done_out_result", out_result, exp_res);
    chk("done_out_misalign", out_misalign, 0);
    chk("done_dreq_valid", dreq_valid, 0);
    chk("done_stall_cycles", 64'(stall_cycles), 64'(waits + 1));
    txn++;
    $display("txn %0d %s addr=0x%0h size=%0d sign=%0d waits=%0d result=0x%0h",
             txn, is_store ? "store" : "load", addr, size, sgn, waits, out_result);
  endtask

  // ---- stimulus ------------------------------------------------------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_addr = '0; in_wdata = '0; in_size = '0; in_sign = 1'b0;
    in_rd = '0; in_wen = 1'b0; in_alu = '0; dresp_ok = 1'b0; dresp_data = '0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_dreq_strobe", dreq_strobe, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b0;
    $display("txn 0 reset");

    // Directed scenarios.
    do_alu(5'd3, 1'b1, 64'h1234);
    do_mem(1'b0, 64'h1003, 64'h0, 0, 1'b1, 5'd7, 1'b1, 2, 64'h0000_0000_8000_0000);
    chk("signed_byte_const", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    do_mem(1'b1, 64'h2006, 64'hBEEF, 1, 1'b0, 5'd9, 1'b1, 1, 64'h0);
    chk("store_half_strobe_const", {56'd0, model_strobe(6, 1)}, 64'hC0);
    do_mem(1'b0, 64'h1002, 64'h0, 2, 1'b0, 5'd4, 1'b1, 0, 64'h0);
    do_mem(1'b0, 64'h3000, 64'h0, 3, 1'b0, 5'd10, 1'b1, 0, 64'h0123_4567_89AB_CDEF);
    do_mem(1'b0, 64'h3008, 64'h0, 3, 1'b0, 5'd11, 1'b1, 0, 64'hFEDC_BA98_7654_3210);
    do_idle();

    // Reset while a request is outstanding, with a completion in the same cycle.
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_addr = 64'h4000;
    in_size = 2'd3; in_rd = 5'd12; in_wen = 1'b1;
    #1;
    chk("rstwait_issue_stall", stall, 1);
    tick();
    chk("rstwait_dreq_valid_before", dreq_valid, 1);
    rst = 1'b1; dresp_ok = 1'b1; dresp_data = 64'hAAAA_5555_AAAA_5555;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rstwait_dreq_valid", dreq_valid, 0);
    chk("rstwait_stall", stall, 0);
    chk("rstwait_out_valid", out_valid, 0);
    chk("rstwait_out_result", out_result, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rstwait_late_ok_out_valid", out_valid, 0);
      chk("rstwait_late_ok_dreq_valid", dreq_valid, 0);
    end
    dresp_ok = 1'b0;
    txn++;
    $display("txn %0d reset during wait", txn);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      int          kind;
      int          size;
      logic [63:0] addr;
      kind = int'($urandom_range(0, 9));
      size = int'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      if (kind < 2) begin
        do_alu(5'($urandom), 1'($urandom), {$urandom, $urandom});
      end else if (kind < 3) begin
        do_idle();
      end else begin
        do_mem(kind >= 7, addr, {$urandom, $urandom}, size, 1'($urandom),
               5'($urandom), 1'($urandom), int'($urandom_range(0, 3)), {$urandom, $urandom});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
